// File: rtl/aes_decrypt_core_if.sv
// Start/busy/done request bus between a client and the decrypt core.
interface aes_decrypt_core_if;
  localparam int unsigned W = 128;

  logic         start;
  logic [W-1:0] key;
  logic [W-1:0] data_in;
  logic [W-1:0] data_out;
  logic         busy;
  logic         done;

  modport master (output start, key, data_in, input data_out, busy, done);
  modport slave  (input start, key, data_in, output data_out, busy, done);
endinterface

// File: rtl/aes_decrypt_core.sv
// Iterative inverse of the simplified round cipher: expands the key forward to
// the last round key, whitens, then unwinds the rounds back to the plaintext.
module aes_decrypt_core #(
  parameter int unsigned ROUNDS = 10
) (
  input logic              clk,
  input logic              rst,
  aes_decrypt_core_if.slave bus
);
  localparam int unsigned W  = 128;
  localparam int unsigned RW = 8;
  localparam logic [RW-1:0] RC_LAST = RW'(ROUNDS - 1);

  typedef enum logic [1:0] {IDLE, EXPAND, WHITEN, ROUND} state_e;

  state_e          state_q, state_d;
  logic [RW-1:0]   rc_q, rc_d;
  logic [W-1:0]    st_q, st_d;
  logic [W-1:0]    rk_q, rk_d;
  logic [W-1:0]    dout_q, dout_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;

  logic [W-1:0]    rk_fwd_c;
  logic [W-1:0]    rk_prev_c;
  logic [W-1:0]    round_c;

  function automatic logic [W-1:0] rotl8(input logic [W-1:0] x);
    return {x[W-9:0], x[W-1:W-8]};
  endfunction

  function automatic logic [W-1:0] rotr8(input logic [W-1:0] x);
    return {x[7:0], x[W-1:8]};
  endfunction

  // Round constant is 8-bit and wraps, so rc=255 yields 0 in the low byte.
  function automatic logic [W-1:0] rcon(input logic [RW-1:0] r);
    return {{(W - RW){1'b0}}, RW'(r + RW'(1))};
  endfunction

  assign rk_fwd_c  = rotl8(rk_q) ^ rcon(rc_q);
  assign rk_prev_c = rotr8(rk_q ^ rcon(rc_q));
  assign round_c   = rotr8(st_q) ^ rk_prev_c;

  always_comb begin
    state_d = state_q;
    rc_d    = rc_q;
    st_d    = st_q;
    rk_d    = rk_q;
    dout_d  = dout_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          rk_d    = bus.key;
          st_d    = bus.data_in;
          rc_d    = '0;
          busy_d  = 1'b1;
          state_d = EXPAND;
        end
      end
      EXPAND: begin
        rk_d = rk_fwd_c;
        rc_d = RW'(rc_q + RW'(1));
        if (rc_q == RC_LAST) state_d = WHITEN;
      end
      WHITEN: begin
        st_d    = st_q ^ rk_q;
        rc_d    = RC_LAST;
        state_d = ROUND;
      end
      ROUND: begin
        st_d = round_c;
        rk_d = rk_prev_c;
        rc_d = RW'(rc_q - RW'(1));
        if (rc_q == '0) begin
          dout_d  = round_c;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      rc_q    <= '0;
      st_q    <= '0;
      rk_q    <= '0;
      dout_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rc_q    <= rc_d;
      st_q    <= st_d;
      rk_q    <= rk_d;
      dout_q  <= dout_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.data_out = dout_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
endmodule

// File: tb/tb_aes_decrypt_core.sv
// Directed bench for aes_decrypt_core with ROUNDS=1 and ROUNDS=10 instances.
module tb_aes_decrypt_core;
  logic clk;
  logic rst;
  int   vec_cnt;
  int   err_cnt;

  aes_decrypt_core_if if1 ();
  aes_decrypt_core_if if10 ();

  aes_decrypt_core #(.ROUNDS(1))  dut1  (.clk(clk), .rst(rst), .bus(if1));
  aes_decrypt_core #(.ROUNDS(10)) dut10 (.clk(clk), .rst(rst), .bus(if10));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  function automatic logic [127:0] rotl8(input logic [127:0] x);
    return {x[119:0], x[127:120]};
  endfunction

  // Forward cipher straight from its definition, used to make ciphertexts.
  function automatic logic [127:0] encrypt(input logic [127:0] pt, input logic [127:0] key,
                                           input int rounds);
    logic [127:0] s, rk;
    s  = pt;
    rk = key;
    for (int r = 0; r < rounds; r++) begin
      s  = rotl8(s ^ rk);
      rk = rotl8(rk) ^ {120'd0, 8'(r + 1)};
    end
    return s ^ rk;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full ROUNDS=10 operation: returns result, done latency and busy cycle count.
  task automatic run10(input logic [127:0] ct, input logic [127:0] key,
                       output logic [127:0] got, output int lat, output int bcnt);
    if10.start   = 1'b1;
    if10.key     = key;
    if10.data_in = ct;
    tick();
    if10.start = 1'b0;
    bcnt = if10.busy ? 1 : 0;
    lat  = 0;
    for (int i = 1; i <= 60; i++) begin
      tick();
      if (if10.busy) bcnt++;
      if (if10.done) begin
        lat = i;
        break;
      end
    end
    got = if10.data_out;
  endtask

  task automatic run1(input logic [127:0] ct, input logic [127:0] key,
                      output logic [127:0] got, output int lat);
    if1.start   = 1'b1;
    if1.key     = key;
    if1.data_in = ct;
    tick();
    if1.start = 1'b0;
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (if1.done) begin
        lat = i;
        break;
      end
    end
    got = if1.data_out;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    if1.start = 1'b0;  if1.key = '0;  if1.data_in = '0;
    if10.start = 1'b0; if10.key = '0; if10.data_in = '0;
    repeat (3) tick();
    rst = 1'b0;
    vec_cnt++;
    if ({if1.busy, if1.done, if10.busy, if10.done} !== 4'b0000) begin
      err_cnt++;
      $display("FAIL reset_flags got=%b exp=0000", {if1.busy, if1.done, if10.busy, if10.done});
    end
    vec_cnt++;
    if (if10.data_out !== 128'h0 || if1.data_out !== 128'h0) begin
      err_cnt++;
      $display("FAIL reset_data got=%h/%h exp=0", if1.data_out, if10.data_out);
    end
  endtask

  task automatic test_rounds1();
    logic [127:0] got;
    int lat;
    run1(128'h1, 128'h0, got, lat);
    vec_cnt++;
    if (lat !== 3) begin err_cnt++; $display("FAIL r1_lat_a got=%0d exp=3", lat); end
    vec_cnt++;
    if (got !== 128'h0) begin err_cnt++; $display("FAIL r1_data_a got=%h exp=0", got); end
    run1(128'h0, 128'h0, got, lat);
    vec_cnt++;
    if (lat !== 3) begin err_cnt++; $display("FAIL r1_lat_b got=%0d exp=3", lat); end
    vec_cnt++;
    if (got !== 128'h0100_0000_0000_0000_0000_0000_0000_0000) begin
      err_cnt++;
      $display("FAIL r1_data_b got=%h exp=%h", got, 128'h0100_0000_0000_0000_0000_0000_0000_0000);
    end
  endtask

  task automatic test_random();
    logic [127:0] pt, key, got;
    int lat, bcnt;
    for (int n = 0; n < 200; n++) begin
      pt  = rand128();
      key = rand128();
      run10(encrypt(pt, key, 10), key, got, lat, bcnt);
      vec_cnt++;
      if (got !== pt) begin err_cnt++; $display("FAIL rand_data[%0d] got=%h exp=%h", n, got, pt); end
      vec_cnt++;
      if (lat !== 21) begin err_cnt++; $display("FAIL rand_lat[%0d] got=%0d exp=21", n, lat); end
      vec_cnt++;
      if (bcnt !== 21) begin err_cnt++; $display("FAIL rand_busy[%0d] got=%0d exp=21", n, bcnt); end
    end
  endtask

  task automatic test_start_ignored();
    logic [127:0] pt, key;
    int lat, dcnt;
    pt  = 128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210;
    key = 128'h2b7e_1516_28ae_d2a6_abf7_1588_09cf_4f3c;
    if10.start = 1'b1; if10.key = key; if10.data_in = encrypt(pt, key, 10);
    tick();
    lat = 0; dcnt = 0;
    for (int i = 1; i <= 40; i++) begin
      if10.start   = (i == 5 || i == 15);
      if10.key     = ~key;
      if10.data_in = rand128();
      tick();
      if (if10.done) begin
        dcnt++;
        if (lat == 0) lat = i;
      end
    end
    vec_cnt++;
    if (if10.data_out !== pt) begin err_cnt++; $display("FAIL ign_data got=%h exp=%h", if10.data_out, pt); end
    vec_cnt++;
    if (lat !== 21) begin err_cnt++; $display("FAIL ign_lat got=%0d exp=21", lat); end
    vec_cnt++;
    if (dcnt !== 1) begin err_cnt++; $display("FAIL ign_done_count got=%0d exp=1", dcnt); end
  endtask

  task automatic test_mid_reset();
    logic [127:0] pt, key, got;
    int lat, bcnt, dcnt;
    key = 128'hdead_beef_0000_1111_2222_3333_4444_5555;
    pt  = 128'h0f0e_0d0c_0b0a_0908_0706_0504_0302_0100;
    if10.start = 1'b1; if10.key = key; if10.data_in = encrypt(pt, key, 10);
    tick();
    if10.start = 1'b0;
    repeat (7) tick();
    rst = 1'b1; if10.start = 1'b1; if10.data_in = rand128();
    tick();
    rst = 1'b0; if10.start = 1'b0;
    vec_cnt++;
    if ({if10.busy, if10.done} !== 2'b00) begin
      err_cnt++; $display("FAIL mrst_flags got=%b exp=00", {if10.busy, if10.done});
    end
    vec_cnt++;
    if (if10.data_out !== 128'h0) begin err_cnt++; $display("FAIL mrst_data got=%h exp=0", if10.data_out); end
    dcnt = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (if10.done || if10.busy) dcnt++;
    end
    vec_cnt++;
    if (dcnt !== 0) begin err_cnt++; $display("FAIL mrst_quiet got=%0d exp=0", dcnt); end
    run10(encrypt(pt, key, 10), key, got, lat, bcnt);
    vec_cnt++;
    if (got !== pt) begin err_cnt++; $display("FAIL mrst_after got=%h exp=%h", got, pt); end
    vec_cnt++;
    if (lat !== 21) begin err_cnt++; $display("FAIL mrst_after_lat got=%0d exp=21", lat); end
  endtask

  task automatic test_back_to_back();
    logic [127:0] pa, pb, ka, kb, got;
    int lat, bcnt;
    pa = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
    ka = 128'h0;
    pb = 128'hffff_0000_ffff_0000_a5a5_5a5a_c3c3_3c3c;
    kb = 128'h0011_2233_4455_6677_8899_aabb_ccdd_eeff;
    run10(encrypt(pa, ka, 10), ka, got, lat, bcnt);
    vec_cnt++;
    if (got !== pa) begin err_cnt++; $display("FAIL b2b_first got=%h exp=%h", got, pa); end
    if10.start = 1'b1; if10.key = kb; if10.data_in = encrypt(pb, kb, 10);
    tick();
    if10.start = 1'b0;
    vec_cnt++;
    if (if10.busy !== 1'b1) begin err_cnt++; $display("FAIL b2b_accept got=%b exp=1", if10.busy); end
    lat = 0;
    for (int i = 2; i <= 60; i++) begin
      tick();
      if (if10.done) begin
        lat = i;
        break;
      end
    end
    vec_cnt++;
    if (lat !== 22) begin err_cnt++; $display("FAIL b2b_gap got=%0d exp=22", lat); end
    vec_cnt++;
    if (if10.data_out !== pb) begin err_cnt++; $display("FAIL b2b_second got=%h exp=%h", if10.data_out, pb); end
  endtask

  initial begin
    vec_cnt = 0;
    err_cnt = 0;
    rst = 1'b1;
    test_reset();
    test_rounds1();
    test_random();
    test_start_ignored();
    test_mid_reset();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end
endmodule
